// File: rtl/canv_disp_pix_pkg.sv
// Shared graphics constants and helpers for the canvas display pixel path.
// The display top level uses GFX_PIX_LAT when it computes its own bitmap latency,
// and the blitter uses the bpp helpers.
package canv_disp_pix_pkg;

    localparam int GFX_WORD    = 32;
    localparam int GFX_CIDXW   = 8;
    localparam int GFX_COLRW   = 15;
    localparam int GFX_PIX_LAT = 4;

    // Where the pixel colour comes from at the end of the pipe.
    typedef enum logic {
        MODE_PAL    = 1'b0,
        MODE_DIRECT = 1'b1
    } colr_mode_e;

    // A shift wider than log2(word) would mean pixels narrower than one bit.
    // Such a shift is treated as 1 bpp.
    function automatic int unsigned gfx_clamp_shift(input int unsigned shift,
                                                    input int unsigned logw);
        return (shift > logw) ? logw : shift;
    endfunction

    function automatic int unsigned gfx_bpp(input int unsigned word,
                                            input int unsigned shift,
                                            input int unsigned logw);
        return word >> gfx_clamp_shift(shift, logw);
    endfunction

endpackage

// File: rtl/pix_extract.sv
// Pixel field extraction from a packed word. Pixel 0 sits in the LSBs.
// The result is zero-extended to the full word width. The block is purely
// combinational and is shared with the blitter.
module pix_extract
    import canv_disp_pix_pkg::*;
#(
    parameter int WORD    = GFX_WORD,
    parameter int SHIFTW  = 3,
    parameter int PIX_IDW = $clog2(WORD)
) (
    input  logic [WORD-1:0]    word,
    input  logic [PIX_IDW-1:0] pix_id,
    input  logic [SHIFTW-1:0]  addr_shift,
    output logic [WORD-1:0]    field
);

    localparam int unsigned LOGW  = $clog2(WORD);
    localparam int unsigned WORDU = WORD;

    int unsigned     sh;
    int unsigned     bpp;
    int unsigned     pid;
    int unsigned     off;
    logic [WORD-1:0] mask;

    // bpp is a power of two, so the bit offset is the masked pixel id shifted up, with no multiplier.
    always_comb begin
        sh    = gfx_clamp_shift(32'(addr_shift), LOGW);
        bpp   = gfx_bpp(WORDU, 32'(addr_shift), LOGW);
        pid   = 32'(pix_id) & ((32'd1 << sh) - 32'd1);
        off   = pid << (LOGW - sh);
        mask  = (bpp >= WORDU) ? '1 : (({{(WORD-1){1'b0}}, 1'b1} << bpp) - 1'b1);
        field = (word >> off) & mask;
    end

endmodule

// File: rtl/canv_disp_pix.sv
// Canvas display pixel pipeline. The pipe has a fixed latency of 4 cycles and
// never stalls.
//   E+1: VRAM request, with a one-word cache so that a run of pixels in one word
//        causes a single read.
//   E+2: the word register captures VRAM data, and the field is extracted.
//   E+3: the CLUT address is issued, or the direct colour is latched.
//   E+4: the colour is output (CLUT data, direct colour or background).
module canv_disp_pix
    import canv_disp_pix_pkg::*;
#(
    parameter int WORD    = GFX_WORD,
    parameter int ADDRW   = 0,
    parameter int SHIFTW  = 0,
    parameter int PIX_IDW = $clog2(WORD),
    parameter int CIDXW   = GFX_CIDXW,
    parameter int COLRW   = GFX_COLRW
) (
    input  logic               clk_pix,
    input  logic               rst_pix,
    input  logic               frame_start,
    input  logic [ADDRW-1:0]   addr,
    input  logic [PIX_IDW-1:0] pix_id,
    input  logic               paint,
    input  logic [SHIFTW-1:0]  addr_shift,
    input  logic [COLRW-1:0]   bg_colr,
    output logic [ADDRW-1:0]   vram_addr,
    output logic               vram_re,
    input  logic [WORD-1:0]    vram_data,
    output logic [CIDXW-1:0]   clut_addr,
    input  logic [COLRW-1:0]   clut_data,
    output logic [COLRW-1:0]   colr,
    output logic               paint_out
);

    localparam int unsigned LOGW   = $clog2(WORD);
    localparam int unsigned WORDU  = WORD;
    localparam int unsigned CIDXWU = CIDXW;

    // stage 1
    logic               vram_re_d, vram_re_q;
    logic [ADDRW-1:0]   vram_addr_q;
    logic               cache_valid_d, cache_valid_q;
    logic [ADDRW-1:0]   cache_addr_q;
    logic               vld1_q;
    logic [SHIFTW-1:0]  shift1_q;
    logic [PIX_IDW-1:0] pid1_q;

    // stage 2
    logic [WORD-1:0]    word_q;
    logic               vld2_q;
    logic [SHIFTW-1:0]  shift2_q;
    logic [PIX_IDW-1:0] pid2_q;
    logic [WORD-1:0]    field_w;
    colr_mode_e         mode2;

    // stage 3
    logic               vld3_q;
    colr_mode_e         mode3_q;
    logic [COLRW-1:0]   dcol3_q;
    logic [COLRW-1:0]   bg3_q;
    logic [CIDXW-1:0]   clut_addr_q;

    // stage 4
    logic [COLRW-1:0]   colr_d, colr_q;
    logic               paint_out_q;

    // Cache lookup. frame_start forces a miss, so the first paint of a frame always re-reads VRAM.
    always_comb begin
        vram_re_d     = paint && !(cache_valid_q && !frame_start && (addr == cache_addr_q));
        cache_valid_d = cache_valid_q;
        if (vram_re_d)
            cache_valid_d = 1'b1;
        else if (frame_start)
            cache_valid_d = 1'b0;
    end

    // Stage 1 control: VRAM request, cache valid and the paint valid bit.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            vram_re_q     <= 1'b0;
            vram_addr_q   <= '0;
            cache_valid_q <= 1'b0;
            vld1_q        <= 1'b0;
        end else begin
            vram_re_q     <= vram_re_d;
            vram_addr_q   <= addr;
            cache_valid_q <= cache_valid_d;
            vld1_q        <= paint;
        end
    end

    // Stage 1 and 2 data. These registers are only observed behind a valid bit or after a read, so they are not reset.
    always_ff @(posedge clk_pix) begin
        if (vram_re_d)
            cache_addr_q <= addr;
        shift1_q <= addr_shift;
        pid1_q   <= pix_id;
        if (vram_re_q)
            word_q <= vram_data;
        shift2_q <= shift1_q;
        pid2_q   <= pid1_q;
    end

    pix_extract #(
        .WORD    (WORD),
        .SHIFTW  (SHIFTW),
        .PIX_IDW (PIX_IDW)
    ) u_extract (
        .word       (word_q),
        .pix_id     (pid2_q),
        .addr_shift (shift2_q),
        .field      (field_w)
    );

    // Pixels wider than a CLUT index carry their colour directly.
    always_comb begin
        mode2 = MODE_PAL;
        if (gfx_bpp(WORDU, 32'(shift2_q), LOGW) > CIDXWU)
            mode2 = MODE_DIRECT;
    end

    // Stage 2 and 3 control: the valid bits and the CLUT address, which moves only for painted palette pixels.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            vld2_q      <= 1'b0;
            vld3_q      <= 1'b0;
            clut_addr_q <= '0;
        end else begin
            vld2_q <= vld1_q;
            vld3_q <= vld2_q;
            if (vld2_q && (mode2 == MODE_PAL))
                clut_addr_q <= CIDXW'(field_w);
        end
    end

    // Stage 3 data: the colour mode, the direct colour and the background colour sampled alongside the pixel.
    always_ff @(posedge clk_pix) begin
        mode3_q <= mode2;
        dcol3_q <= COLRW'(field_w);
        bg3_q   <= bg_colr;
    end

    // Final colour select.
    always_comb begin
        colr_d = bg3_q;
        if (vld3_q)
            colr_d = (mode3_q == MODE_DIRECT) ? dcol3_q : clut_data;
    end

    // Output register.
    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            colr_q      <= '0;
            paint_out_q <= 1'b0;
        end else begin
            colr_q      <= colr_d;
            paint_out_q <= vld3_q;
        end
    end

    assign vram_re   = vram_re_q;
    assign vram_addr = vram_addr_q;
    assign clut_addr = clut_addr_q;
    assign colr      = colr_q;
    assign paint_out = paint_out_q;

endmodule

// File: tb/tb_canv_disp_pix.sv
// Directed bench for canv_disp_pix. The stimulus pushes hand-computed expectations
// into queues. A monitor checks vram_re at E+1, clut_addr at E+3, and
// colr/paint_out at E+4.
module tb_canv_disp_pix;
    import canv_disp_pix_pkg::*;

    localparam int WORD    = 32;
    localparam int ADDRW   = 8;
    localparam int SHIFTW  = 3;
    localparam int PIX_IDW = 5;
    localparam int CIDXW   = 8;
    localparam int COLRW   = 15;
    localparam logic [14:0] BG = 15'h1234;

    logic               clk_pix = 1'b0;
    logic               rst_pix;
    logic               frame_start;
    logic [ADDRW-1:0]   addr;
    logic [PIX_IDW-1:0] pix_id;
    logic               paint;
    logic [SHIFTW-1:0]  addr_shift;
    logic [COLRW-1:0]   bg_colr;
    logic [ADDRW-1:0]   vram_addr;
    logic               vram_re;
    logic [WORD-1:0]    vram_data;
    logic [CIDXW-1:0]   clut_addr;
    logic [COLRW-1:0]   clut_data;
    logic [COLRW-1:0]   colr;
    logic               paint_out;

    canv_disp_pix #(
        .WORD(WORD), .ADDRW(ADDRW), .SHIFTW(SHIFTW),
        .PIX_IDW(PIX_IDW), .CIDXW(CIDXW), .COLRW(COLRW)
    ) dut (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .frame_start(frame_start),
        .addr(addr), .pix_id(pix_id), .paint(paint), .addr_shift(addr_shift),
        .bg_colr(bg_colr), .vram_addr(vram_addr), .vram_re(vram_re),
        .vram_data(vram_data), .clut_addr(clut_addr), .clut_data(clut_data),
        .colr(colr), .paint_out(paint_out)
    );

    always #5 clk_pix = ~clk_pix;

    // Memory models with a registered address, so the data is valid in the cycle after the address.
    logic [WORD-1:0] vmem [0:255];
    assign vram_data = vmem[vram_addr];

    function automatic logic [14:0] clut_f(input logic [7:0] a);
        return {a, 7'h00} ^ 15'h1555;
    endfunction
    assign clut_data = clut_f(clut_addr);

    typedef struct {
        string       name;
        logic        re;
        logic        chk_ca;
        logic [7:0]  ca;
        logic        po;
        logic [14:0] colr;
    } exp_t;

    exp_t q_re[$];
    exp_t q_ca[$];
    exp_t q_out[$];

    int total = 0;
    int bad   = 0;
    logic issuing = 1'b0;
    logic mon_en  = 1'b0;
    logic [GFX_PIX_LAT:1] iss = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    // Track the age of each issued sample. A reset drops everything in flight.
    always @(posedge clk_pix) begin
        if (rst_pix) begin
            iss <= '0;
            q_re.delete();
            q_ca.delete();
            q_out.delete();
        end else begin
            iss <= {iss[GFX_PIX_LAT-1:1], issuing};
        end
    end

    always @(negedge clk_pix) begin
        exp_t e;
        if (mon_en) begin
            if (iss[1]) begin
                if (q_re.size() == 0) chk("q_re underflow", 1, 0);
                else begin
                    e = q_re.pop_front();
                    chk($sformatf("%s vram_re", e.name), 32'(vram_re), 32'(e.re));
                end
            end else begin
                chk("idle vram_re", 32'(vram_re), 0);
            end
            if (iss[3]) begin
                if (q_ca.size() == 0) chk("q_ca underflow", 1, 0);
                else begin
                    e = q_ca.pop_front();
                    if (e.chk_ca) chk($sformatf("%s clut_addr", e.name), 32'(clut_addr), 32'(e.ca));
                end
            end
            if (iss[GFX_PIX_LAT]) begin
                if (q_out.size() == 0) chk("q_out underflow", 1, 0);
                else begin
                    e = q_out.pop_front();
                    chk($sformatf("%s paint_out", e.name), 32'(paint_out), 32'(e.po));
                    chk($sformatf("%s colr", e.name), 32'(colr), 32'(e.colr));
                end
            end else begin
                chk("idle paint_out", 32'(paint_out), 0);
            end
        end
    end

    task automatic px(input string nm, input logic fs, input logic [7:0] a,
                      input logic [4:0] pid, input logic [2:0] sh, input logic pnt,
                      input logic re, input logic chk_ca, input logic [7:0] ca,
                      input logic [14:0] col);
        exp_t e;
        @(negedge clk_pix);
        frame_start = fs; addr = a; pix_id = pid; addr_shift = sh; paint = pnt;
        issuing = 1'b1;
        e.name = nm; e.re = re; e.chk_ca = chk_ca; e.ca = ca; e.po = pnt; e.colr = col;
        q_re.push_back(e);
        q_ca.push_back(e);
        q_out.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_pix);
            paint = 1'b0; frame_start = 1'b0; issuing = 1'b0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) vmem[i] = '0;
        vmem[8'h10] = 32'h4433_2211;
        vmem[8'h20] = 32'h8000_0001;
        vmem[8'h30] = 32'hABCD_7FFF;
        rst_pix = 1'b1; frame_start = 1'b0; addr = '0; pix_id = '0;
        paint = 1'b0; addr_shift = '0; bg_colr = BG;

        repeat (3) @(negedge clk_pix);
        chk("rst vram_re", 32'(vram_re), 0);
        chk("rst paint_out", 32'(paint_out), 0);
        chk("rst colr", 32'(colr), 0);
        chk("rst clut_addr", 32'(clut_addr), 0);
        chk("rst vram_addr", 32'(vram_addr), 0);
        rst_pix = 1'b0;
        mon_en  = 1'b1;
        idle(2);

        // 8 bpp palette: one read serves the four pixels, and pix_id is masked to 2 bits
        px("p8_0",   0, 8'h10, 0, 2, 1, 1, 1, 8'h11, clut_f(8'h11));
        px("p8_1",   0, 8'h10, 1, 2, 1, 0, 1, 8'h22, clut_f(8'h22));
        px("p8_2",   0, 8'h10, 2, 2, 1, 0, 1, 8'h33, clut_f(8'h33));
        px("p8_3",   0, 8'h10, 3, 2, 1, 0, 1, 8'h44, clut_f(8'h44));
        px("p8_msk", 0, 8'h10, 5, 2, 1, 0, 1, 8'h22, clut_f(8'h22));
        // 1 bpp, including a shift that is clamped (7 is treated as 5)
        px("b1_0",   0, 8'h20, 0,  5, 1, 1, 1, 8'h01, clut_f(8'h01));
        px("b1_1",   0, 8'h20, 1,  5, 1, 0, 1, 8'h00, clut_f(8'h00));
        px("b1_31",  0, 8'h20, 31, 5, 1, 0, 1, 8'h01, clut_f(8'h01));
        px("b1_c31", 0, 8'h20, 31, 7, 1, 0, 1, 8'h01, clut_f(8'h01));
        px("b1_c30", 0, 8'h20, 30, 7, 1, 0, 1, 8'h00, clut_f(8'h00));
        // 4 bpp
        px("b4_3",   0, 8'h10, 3, 3, 1, 1, 1, 8'h02, clut_f(8'h02));
        px("b4_6",   0, 8'h10, 6, 3, 1, 0, 1, 8'h04, clut_f(8'h04));
        // 16 bpp and 32 bpp direct
        px("d16_0",  0, 8'h30, 0, 1, 1, 1, 0, 8'h00, 15'h7FFF);
        px("d16_1",  0, 8'h30, 1, 1, 1, 0, 0, 8'h00, 15'h2BCD);
        px("d32_0",  0, 8'h30, 7, 0, 1, 0, 0, 8'h00, 15'h7FFF);
        // paint=0 gives the background and never touches VRAM or the cache
        px("bg_hit", 0, 8'h30, 0, 1, 0, 0, 0, 8'h00, BG);
        px("bg_mis", 0, 8'h10, 0, 2, 0, 0, 0, 8'h00, BG);
        px("d16_h",  0, 8'h30, 0, 1, 1, 0, 0, 8'h00, 15'h7FFF);
        // the previous line ends at 0x10; the new frame must re-read changed VRAM
        px("ln_0",   0, 8'h10, 0, 2, 1, 1, 1, 8'h11, clut_f(8'h11));
        idle(6);
        vmem[8'h10] = 32'h8877_6655;
        px("fs_0",   1, 8'h10, 0, 2, 1, 1, 1, 8'h55, clut_f(8'h55));
        px("fs_3",   0, 8'h10, 3, 2, 1, 0, 1, 8'h88, clut_f(8'h88));
        // frame_start without paint still invalidates
        px("fs_bg",  1, 8'h10, 0, 2, 0, 0, 0, 8'h00, BG);
        px("fs_rd",  0, 8'h10, 1, 2, 1, 1, 1, 8'h66, clut_f(8'h66));
        // back-to-back misses with the shift changed between pixels
        px("alt_a",  0, 8'h20, 31, 5, 1, 1, 1, 8'h01, clut_f(8'h01));
        px("alt_b",  0, 8'h10, 2,  2, 1, 1, 1, 8'h77, clut_f(8'h77));
        // reset mid-line: both pixels in flight are lost, and the cache is cold again
        px("rs_0",   0, 8'h20, 0, 5, 1, 1, 1, 8'h01, clut_f(8'h01));
        px("rs_1",   0, 8'h20, 1, 5, 1, 0, 1, 8'h00, clut_f(8'h00));
        @(negedge clk_pix);
        rst_pix = 1'b1; issuing = 1'b0; paint = 1'b1;
        repeat (2) @(negedge clk_pix);
        rst_pix = 1'b0; paint = 1'b0;
        px("post_0", 0, 8'h20, 31, 5, 1, 1, 1, 8'h01, clut_f(8'h01));
        idle(8);

        chk("q_re drained", q_re.size(), 0);
        chk("q_ca drained", q_ca.size(), 0);
        chk("q_out drained", q_out.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/canv_disp_pix.md
CANV_DISP_PIX -- requirements
Module: canv_disp_pix

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- WORD, 32, machine word and VRAM data width (bits).
- ADDRW, 0, VRAM address width (bits); must be overridden.
- SHIFTW, 0, address shift width (bits); must be overridden.
- PIX_IDW, $clog2(WORD), pixel ID width (bits).
- CIDXW, 8, CLUT index width (bits).
- COLRW, 15, output colour width (bits).
REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk_pix, in, 1, pixel clock; the block's only clock.
- rst_pix, in, 1, synchronous active-high reset.
- frame_start, in, 1, frame start flag; invalidates the word cache.
- addr, in, ADDRW, pixel word address from the display AGU.
- pix_id, in, PIX_IDW, pixel ID within the word.
- paint, in, 1, canvas painting enable.
- addr_shift, in, SHIFTW, log2 of pixels per word.
- bg_colr, in, COLRW, background colour.
- vram_addr, out, ADDRW, VRAM read address.
- vram_re, out, 1, VRAM read enable.
- vram_data, in, WORD, VRAM read data; valid 1 cycle after vram_re.
- clut_addr, out, CIDXW, CLUT read address.
- clut_data, in, COLRW, CLUT read data; valid 1 cycle after clut_addr.
- colr, out, COLRW, output pixel colour.
- paint_out, out, 1, delayed paint.
REQ-003 The block SHALL have one clock, clk_pix, and a synchronous active-high reset, rst_pix.

Function
REQ-004 Inputs SHALL be sampled at edge E. colr and paint_out SHALL be valid after edge E+4, a fixed latency of 4 cycles with no stalls.
REQ-005 At E+1, vram_addr SHALL equal addr, and vram_re SHALL equal paint AND NOT (cache_valid AND addr == cache_addr).
REQ-006 When vram_re is issued, cache_addr SHALL be updated to addr and cache_valid SHALL be set at E+1.
REQ-007 frame_start SHALL clear cache_valid. If frame_start coincides with paint, the invalidate SHALL take priority, so a read is issued for that addr.
REQ-008 At E+2, the word register SHALL load vram_data if vram_re was asserted at E+1; otherwise it SHALL hold its value.
REQ-009 bpp SHALL be WORD >> addr_shift. An addr_shift greater than $clog2(WORD) SHALL be clamped to $clog2(WORD) (1 bpp).
REQ-010 The pixel field SHALL be word[pix_id*bpp +: bpp]. Pixel 0 SHALL occupy the LSBs. pix_id SHALL be masked to the low addr_shift bits.
REQ-011 Palette mode (bpp <= CIDXW): at E+3, clut_addr SHALL be the field zero-extended to CIDXW, and at E+4 colr SHALL equal clut_data.
REQ-012 Direct mode (bpp > CIDXW): at E+4, colr SHALL equal field[COLRW-1:0], zero-extended if bpp < COLRW. clut_data SHALL be ignored in this mode.
REQ-013 When the delayed paint is 0 at E+4, colr SHALL equal bg_colr sampled at E+3, and paint_out SHALL be 0.
REQ-014 addr_shift, pix_id and paint SHALL be pipelined alongside the data so that a shift change mid-line affects only the pixels sampled after the change.
REQ-015 The block SHALL make no CLUT or VRAM access assumptions beyond the 1-cycle read latency of each.

Reset
REQ-016 On rst_pix, vram_re, paint_out, cache_valid and all pipeline valid bits SHALL be cleared.
REQ-017 On rst_pix, colr, clut_addr and vram_addr SHALL be set to 0.
REQ-018 The word register and cache_addr need not be reset; they SHALL be unobservable until the first read after reset.
REQ-019 A reset asserted mid-line SHALL cancel all in-flight pixels. The first post-reset output SHALL appear 4 cycles after the first post-reset sample.

Structure
REQ-020 The WORD, CIDXW and COLRW defaults and the pipeline latency constant (4) SHALL live in the shared gfx package, for use by the display top-level BMAP_LAT computation.
REQ-021 Field extraction SHALL be one combinational sub-module, pix_extract (inputs: word, pix_id, addr_shift; output: field of WORD bits). It SHALL be reused by the blitter.

Verification
REQ-022 The bench SHALL cover at least the following directed scenarios (stimulus -> required response).
- 8 bpp palette (addr_shift=2, addr=0x10 for 4 cycles, pix_id 0..3, vram_data=0x44332211) -> a single vram_re; clut_addr 0x11, 0x22, 0x33, 0x44; colr equals the CLUT model output at E+4.
- 1 bpp (addr_shift=5, vram_data=0x80000001, pix_id 0, 1, 31) -> clut_addr 1, 0, 1.
- 16 bpp direct (addr_shift=1, vram_data=0xABCD7FFF, pix_id 0, 1) -> colr 0x7FFF, then 0x2BCD; clut_data ignored.
- paint=0 with bg_colr=0x1234 -> vram_re=0, paint_out=0, colr=0x1234 at E+4.
- frame_start together with paint at the same addr=0x10 as the previous line -> vram_re asserted; the new vram_data is used.
- rst_pix pulsed mid-line while paint=1 -> paint_out=0 for 4 cycles after release; first valid pixel follows the new samples.
